// File: rtl/xregfile_pkg.sv
// ---------------------------------------------------------------------------
// xregfile_pkg : shared types, default width and index-width helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package xregfile_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int c_XLEN_DEFAULT = 32;

   function automatic int idx_width(input int nreg);
      return $clog2(nreg);
   endfunction

endpackage

`default_nettype wire

// File: rtl/xregfile_if.sv
// ---------------------------------------------------------------------------
// xregfile_if : dual write / dual read port bundle of the register file
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface xregfile_if
   import xregfile_pkg::*;
#(
   parameter int XLEN = c_XLEN_DEFAULT,
   parameter int NREG = 16
);
   localparam int IW = idx_width(NREG);

   logic            wreq0;
   logic            wreq1;
   logic [IW-1:0]   windex0;
   logic [IW-1:0]   windex1;
   logic [XLEN-1:0] wdata0;
   logic [XLEN-1:0] wdata1;
   logic [IW-1:0]   rindex0;
   logic [IW-1:0]   rindex1;
   logic [XLEN-1:0] rdata0;
   logic [XLEN-1:0] rdata1;
   logic            ready;

   modport master (
      output wreq0, wreq1, windex0, windex1, wdata0, wdata1, rindex0, rindex1,
      input  rdata0, rdata1, ready
   );

   modport slave (
      input  wreq0, wreq1, windex0, windex1, wdata0, wdata1, rindex0, rindex1,
      output rdata0, rdata1, ready
   );

endinterface

`default_nettype wire

// File: rtl/xregfile_rdport.sv
// ---------------------------------------------------------------------------
// xregfile_rdport : one registered read port with same-cycle write bypass
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xregfile_rdport
   import xregfile_pkg::*;
#(
   parameter  int XLEN = c_XLEN_DEFAULT,
   parameter  int NREG = 16,
   localparam int IW   = idx_width(NREG)
)
(
   input  wire logic                      clk,
   input  wire logic                      rst,
   input  wire logic                      i_en,
   input  wire logic [IW-1:0]             i_rindex,
   input  wire logic [NREG-1:0][XLEN-1:0] i_regs,
   input  wire logic                      i_we0,
   input  wire logic [IW-1:0]             i_windex0,
   input  wire logic [XLEN-1:0]           i_wdata0,
   input  wire logic                      i_we1,
   input  wire logic [IW-1:0]             i_windex1,
   input  wire logic [XLEN-1:0]           i_wdata1,
   output logic      [XLEN-1:0]           o_rdata
);

   logic [XLEN-1:0] w_rnext;
   logic [XLEN-1:0] r_rdata;

   // Port 1 is checked first so it wins a same-index collision.
   always_comb begin
      w_rnext = i_regs[i_rindex];
      if (i_rindex == '0)
         w_rnext = '0;
      else if (i_we1 && (i_windex1 == i_rindex))
         w_rnext = i_wdata1;
      else if (i_we0 && (i_windex0 == i_rindex))
         w_rnext = i_wdata0;
   end

   always_ff @(posedge clk) begin
      if (rst || !i_en)
         r_rdata <= '0;
      else
         r_rdata <= w_rnext;
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/xregfile_mp.sv
// ---------------------------------------------------------------------------
// xregfile_mp : 2W/2R register file, x0 hard-wired to zero, post-reset clear sweep
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xregfile_mp
   import xregfile_pkg::*;
#(
   parameter int XLEN = c_XLEN_DEFAULT,
   parameter int NREG = 16
)
(
   input wire logic  clk,
   input wire logic  rst,
   xregfile_if.slave bus
);

   localparam int IW = idx_width(NREG);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [IW-1:0]             r_sweep;
   logic [IW-1:0]             w_sweep_nxt;
   logic                      w_run;
   logic                      w_ready;
   logic                      w_clr;
   logic                      w_we0;
   logic                      w_we1;
   logic [XLEN-1:0]           r_regs [1:NREG-1];
   logic [NREG-1:0][XLEN-1:0] w_view;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLEAR;
         r_sweep <= IW'(1);
      end else begin
         r_state <= w_state_nxt;
         r_sweep <= w_sweep_nxt;
      end
   end

   // Next state: the edge that clears the top index also enters RUN
   always_comb begin
      w_state_nxt = r_state;
      w_sweep_nxt = r_sweep;
      case (r_state)
         CLEAR: begin
            w_sweep_nxt = r_sweep + IW'(1);
            if (r_sweep == IW'(NREG - 1))
               w_state_nxt = RUN;
         end
         RUN:     w_state_nxt = RUN;
         default: w_state_nxt = CLEAR;
      endcase
   end

   // Outputs: rst masks everything even when the state register still says RUN
   always_comb begin
      w_run   = (r_state == RUN);
      w_ready = w_run && !rst;
      w_clr   = (r_state == CLEAR) && !rst;
      w_we0   = bus.wreq0 && (bus.windex0 != '0) && w_ready;
      w_we1   = bus.wreq1 && (bus.windex1 != '0) && w_ready;
   end

   assign bus.ready = w_ready;

   // Flop array: each entry decodes both ports so distinct-index writes both land
   always_ff @(posedge clk) begin
      for (int i = 1; i < NREG; i++) begin
         if (w_we1 && (bus.windex1 == IW'(i)))
            r_regs[i] <= bus.wdata1;
         else if (w_we0 && (bus.windex0 == IW'(i)))
            r_regs[i] <= bus.wdata0;
         else if (w_clr && (r_sweep == IW'(i)))
            r_regs[i] <= '0;
      end
   end

   always_comb begin
      w_view[0] = '0;
      for (int i = 1; i < NREG; i++)
         w_view[i] = r_regs[i];
   end

   xregfile_rdport #(.XLEN(XLEN), .NREG(NREG)) u_rd0 (
      .clk       (clk),
      .rst       (rst),
      .i_en      (w_run),
      .i_rindex  (bus.rindex0),
      .i_regs    (w_view),
      .i_we0     (w_we0),
      .i_windex0 (bus.windex0),
      .i_wdata0  (bus.wdata0),
      .i_we1     (w_we1),
      .i_windex1 (bus.windex1),
      .i_wdata1  (bus.wdata1),
      .o_rdata   (bus.rdata0)
   );

   xregfile_rdport #(.XLEN(XLEN), .NREG(NREG)) u_rd1 (
      .clk       (clk),
      .rst       (rst),
      .i_en      (w_run),
      .i_rindex  (bus.rindex1),
      .i_regs    (w_view),
      .i_we0     (w_we0),
      .i_windex0 (bus.windex0),
      .i_wdata0  (bus.wdata0),
      .i_we1     (w_we1),
      .i_windex1 (bus.windex1),
      .i_wdata1  (bus.wdata1),
      .o_rdata   (bus.rdata1)
   );

endmodule

`default_nettype wire

// File: tb/tb_xregfile_mp.sv
// ---------------------------------------------------------------------------
// tb_xregfile_mp : directed vector table plus reset/sweep sequences
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_xregfile_mp;

   localparam int c_XLEN = 32;
   localparam int c_NREG = 16;

   typedef struct {
      logic        wreq0;
      logic [3:0]  windex0;
      logic [31:0] wdata0;
      logic        wreq1;
      logic [3:0]  windex1;
      logic [31:0] wdata1;
      logic [3:0]  rindex0;
      logic [3:0]  rindex1;
      logic [31:0] exp0;
      logic [31:0] exp1;
   } vec_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   vec_t vecs [0:10];

   xregfile_if #(.XLEN(c_XLEN), .NREG(c_NREG)) bus ();

   xregfile_mp #(.XLEN(c_XLEN), .NREG(c_NREG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.wreq0   = 1'b0;
      bus.wreq1   = 1'b0;
      bus.windex0 = '0;
      bus.windex1 = '0;
      bus.wdata0  = '0;
      bus.wdata1  = '0;
   endtask

   function automatic vec_t mk(input logic w0, input logic [3:0] i0, input logic [31:0] d0,
                               input logic w1, input logic [3:0] i1, input logic [31:0] d1,
                               input logic [3:0] r0, input logic [3:0] r1,
                               input logic [31:0] e0, input logic [31:0] e1);
      vec_t v;
      v.wreq0 = w0; v.windex0 = i0; v.wdata0 = d0;
      v.wreq1 = w1; v.windex1 = i1; v.wdata1 = d1;
      v.rindex0 = r0; v.rindex1 = r1;
      v.exp0 = e0; v.exp1 = e1;
      return v;
   endfunction

   // Release rst and count edges until ready; optionally keep hammering writes
   task automatic sweep_wait(input string name, input logic hammer);
      int cnt;
      cnt = 0;
      rst = 1'b0;
      while (cnt < 100) begin
         if (hammer) begin
            bus.wreq0 = 1'b1; bus.windex0 = 4'd3; bus.wdata0 = 32'h77;
            bus.wreq1 = 1'b1; bus.windex1 = 4'd4; bus.wdata1 = 32'h88;
            bus.rindex0 = 4'd3; bus.rindex1 = 4'd4;
         end
         tick();
         cnt++;
         if (hammer) begin
            chk({name, "_rd0_clear"}, bus.rdata0, 32'h0);
            chk({name, "_rd1_clear"}, bus.rdata1, 32'h0);
         end
         if (bus.ready === 1'b1) break;
      end
      idle();
      chk({name, "_sweep_len"}, 32'(cnt), 32'd15);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      idle();
      bus.rindex0 = '0;
      bus.rindex1 = '0;

      vecs[0]  = mk(1, 4'd5, 32'hDEADBEEF, 0, 4'd0, 32'h0,      4'd5,  4'd5, 32'hDEADBEEF, 32'hDEADBEEF);
      vecs[1]  = mk(1, 4'd7, 32'h1111,     1, 4'd7, 32'h2222,   4'd7,  4'd5, 32'h2222,     32'hDEADBEEF);
      vecs[2]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,      4'd7,  4'd7, 32'h2222,     32'h2222);
      vecs[3]  = mk(1, 4'd0, 32'hFFFFFFFF, 1, 4'd0, 32'hFFFFFFFF, 4'd0, 4'd0, 32'h0,       32'h0);
      vecs[4]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,      4'd0,  4'd0, 32'h0,        32'h0);
      vecs[5]  = mk(1, 4'd2, 32'h10,       1, 4'd9, 32'h20,     4'd3,  4'd4, 32'h0,        32'h0);
      vecs[6]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,      4'd2,  4'd9, 32'h10,       32'h20);
      vecs[7]  = mk(0, 4'd2, 32'h44,       1, 4'd2, 32'h33,     4'd2,  4'd9, 32'h33,       32'h20);
      vecs[8]  = mk(1, 4'd15, 32'hABCD,    0, 4'd0, 32'h0,      4'd15, 4'd1, 32'hABCD,     32'h0);
      vecs[9]  = mk(1, 4'd9, 32'h55,       0, 4'd9, 32'h66,     4'd9,  4'd15, 32'h55,      32'hABCD);
      vecs[10] = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,      4'd9,  4'd2, 32'h55,       32'h33);

      // Reset held 3 cycles
      repeat (3) tick();
      chk("rst_ready", 32'(bus.ready), 32'h0);
      chk("rst_rd0", bus.rdata0, 32'h0);
      chk("rst_rd1", bus.rdata1, 32'h0);
      sweep_wait("init", 1'b0);

      for (int i = 0; i < c_NREG; i++) begin
         bus.rindex0 = 4'(i);
         bus.rindex1 = 4'(c_NREG - 1 - i);
         tick();
         chk($sformatf("clr_rd0_x%0d", i), bus.rdata0, 32'h0);
         chk($sformatf("clr_rd1_x%0d", c_NREG - 1 - i), bus.rdata1, 32'h0);
      end

      foreach (vecs[i]) begin
         bus.wreq0 = vecs[i].wreq0; bus.windex0 = vecs[i].windex0; bus.wdata0 = vecs[i].wdata0;
         bus.wreq1 = vecs[i].wreq1; bus.windex1 = vecs[i].windex1; bus.wdata1 = vecs[i].wdata1;
         bus.rindex0 = vecs[i].rindex0;
         bus.rindex1 = vecs[i].rindex1;
         tick();
         chk($sformatf("vec%0d_rd0", i), bus.rdata0, vecs[i].exp0);
         chk($sformatf("vec%0d_rd1", i), bus.rdata1, vecs[i].exp1);
         chk($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'h1);
      end
      idle();

      // x3 written in RUN, then wiped by a one-cycle reset and re-sweep
      bus.wreq0 = 1'b1; bus.windex0 = 4'd3; bus.wdata0 = 32'hA5;
      tick();
      idle();
      bus.rindex0 = 4'd3;
      tick();
      chk("x3_written", bus.rdata0, 32'hA5);
      rst = 1'b1;
      bus.wreq0 = 1'b1; bus.windex0 = 4'd3; bus.wdata0 = 32'hFF;
      tick();
      chk("rst_run_ready", 32'(bus.ready), 32'h0);
      chk("rst_run_rd0", bus.rdata0, 32'h0);
      sweep_wait("resweep", 1'b1);
      bus.rindex0 = 4'd3;
      bus.rindex1 = 4'd4;
      tick();
      chk("x3_after_clear", bus.rdata0, 32'h0);
      chk("x4_after_clear", bus.rdata1, 32'h0);

      // Reset in the middle of a sweep restarts it from index 1
      bus.rindex0 = 4'd9;
      bus.rindex1 = 4'd2;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (6) tick();
      chk("mid_sweep_ready", 32'(bus.ready), 32'h0);
      rst = 1'b1;
      tick();
      sweep_wait("restart", 1'b0);
      tick();
      chk("x9_after_restart", bus.rdata0, 32'h0);
      chk("x2_after_restart", bus.rdata1, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
